led_show_sched: RTL
===================

Name: led_show_sched

Overview:
Display scheduler for the 8-bit LED bank of the guess-number game. It sequences the LED register between the idle chase pattern and short event "shows" (guess too high, guess too low, win). Game-logic events arrive over a valid/ready handshake and are scheduled with WIN priority. It sits between the game FSM and the board LED pins, and owns the LED tick prescaler.

Parameters:
TICK_DIV, 50_000_000, clk cycles per display tick (>=2)
SHOW_TICKS, 4, ticks a HIGH/LOW show lasts (>=1)
WIN_TICKS, 8, ticks a WIN show lasts (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
evt_valid  in  1  event offered this cycle
evt_code  in  2  0=NONE, 1=HIGH, 2=LOW, 3=WIN
evt_ready  out  1  event accepted when evt_valid&&evt_ready at posedge clk
led  out  8  LED drive, 1=on
busy  out  1  a show is in progress
mode  out  2  current state encoding

Behaviour:
- Reset (rst=0, async) values: state=IDLE, led=8'b0000_1111, saved chase=8'b0000_1111, tick counter=0, phase counter=0, busy=0, mode=0. Handshake is ignored while rst=0.
- Tick: counter runs 0..TICK_DIV-1 and wraps. tick=1 for one cycle when counter==TICK_DIV-1. The counter clears to 0 on every accepted event, so each show phase is exactly TICK_DIV cycles.
- States and mode encoding: IDLE=0, SHOW_HIGH=1, SHOW_LOW=2, SHOW_WIN=3. busy=(state!=IDLE).
- IDLE:
  - led rotates left by 1 (led <= {led[6:0],led[7]}) on each tick.
  - evt_ready=1.
- Event acceptance (latency 1): on the accepting edge, state goes to SHOW_x, phase counter=0, and led = ON pattern on the next cycle.
  - ON patterns: HIGH=8'hF0, LOW=8'h0F, WIN=8'hFF. OFF pattern=8'h00.
  - Entry from IDLE saves the current chase value.
  - evt_code=NONE with valid: handshake completes, no effect.
- SHOW_x:
  - On each tick, led toggles ON<->OFF and the phase counter increments.
  - On the tick where phase counter==LEN-1 (LEN=SHOW_TICKS or WIN_TICKS): next state=IDLE, led=saved chase, phase=0.
  - An ON/OFF toggle is not applied on that final tick.
- Ready during SHOW_HIGH/SHOW_LOW: evt_ready=1 only when evt_code==WIN.
  - An accepted WIN preempts: SHOW_WIN is entered; the saved chase is not re-captured.
  - HIGH/LOW offered during a show: evt_ready=0, and the offer is held upstream.
- Ready during SHOW_WIN: evt_ready=0 for every code.
- Simultaneous final tick and accepted WIN in SHOW_HIGH/SHOW_LOW: the WIN wins, and SHOW_WIN is entered.
- Chase does not advance during shows. It resumes from the saved value and advances on the first tick after return.
- Reset mid-show: immediate return to reset values. The show is abandoned.

Optional Feature:
EVT_QUEUE_EN
- With: one-entry pending buffer.
  - During SHOW_x, evt_ready = pending empty, for HIGH/LOW/WIN.
  - WIN still preempts HIGH/LOW immediately, bypassing the buffer; a WIN never occupies the buffer unless the current show is SHOW_WIN.
  - When a show ends, a non-empty pending entry starts directly: the next state is SHOW_pending with the ON pattern, the pending slot is cleared, and the tick counter is cleared. IDLE is skipped and the saved chase is retained.
  - NONE is never stored.
- Without: behaviour as above; no buffer.

Decomposition:
- Package led_show_pkg:
  - evt_code constants (EVT_NONE/HIGH/LOW/WIN)
  - state encoding typedef
  - pattern constants (CHASE_INIT=8'b0000_1111, PAT_HIGH, PAT_LOW, PAT_WIN, PAT_OFF)
- Sub-module led_tick_gen: prescaler with a synchronous clear input. Inputs clk, rst, clr; output tick; parameter TICK_DIV.

Test Plan (TICK_DIV=4, SHOW_TICKS=2, WIN_TICKS=4):
- Reset, idle 12 cycles -> led 0x0F, 0x1E, 0x3C, 0x78 at ticks (cycles 4,8,12); busy=0; evt_ready=1.
- HIGH accepted at cycle 5 -> led=0xF0 from cycle 6; 0x00 after 4 cycles; after 8 cycles led=saved chase, state IDLE, busy=0.
- LOW show running, WIN offered -> evt_ready=1, led=0xFF next cycle, mode=3; offered HIGH during WIN sees evt_ready=0 for all 16 cycles.
- WIN offered on the same cycle as the final tick of HIGH -> SHOW_WIN entered, led=0xFF; the chase value saved before HIGH is restored after WIN.
- rst pulled low mid-WIN -> led=0x0F, busy=0, mode=0 asynchronously, before the next clk edge.
- EVT_QUEUE_EN: LOW accepted during HIGH -> the HIGH end cycle goes directly to led=0x0F (LOW ON), mode=2; a second LOW offer sees evt_ready=0.

Source files
------------

// File: rtl/led_show_pkg.sv
// Shared event codes, state encoding and LED patterns for the LED show scheduler.
package led_show_pkg;

    localparam logic [1:0] EVT_NONE = 2'd0;
    localparam logic [1:0] EVT_HIGH = 2'd1;
    localparam logic [1:0] EVT_LOW  = 2'd2;
    localparam logic [1:0] EVT_WIN  = 2'd3;

    // Show states share their encoding with the event code that starts them.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StShowHigh = 2'd1,
        StShowLow  = 2'd2,
        StShowWin  = 2'd3
    } state_e;

    localparam logic [7:0] CHASE_INIT = 8'b0000_1111;
    localparam logic [7:0] PAT_HIGH   = 8'hF0;
    localparam logic [7:0] PAT_LOW    = 8'h0F;
    localparam logic [7:0] PAT_WIN    = 8'hFF;
    localparam logic [7:0] PAT_OFF    = 8'h00;

    function automatic logic [7:0] on_pattern(input logic [1:0] code);
        logic [7:0] pat;
        case (code)
            EVT_HIGH: pat = PAT_HIGH;
            EVT_LOW:  pat = PAT_LOW;
            EVT_WIN:  pat = PAT_WIN;
            default:  pat = PAT_OFF;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Display tick prescaler: one-cycle tick every TICK_DIV clocks, with synchronous clear.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_show_sched.sv
// LED bank scheduler: idle chase plus HIGH/LOW/WIN event shows with WIN priority.
// Optional one-entry pending event buffer enabled by defining EVT_QUEUE_EN.
module led_show_sched
    import led_show_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned SHOW_TICKS = 4,
    parameter int unsigned WIN_TICKS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       evt_valid,
    input  logic [1:0] evt_code,
    output logic       evt_ready,
    output logic [7:0] led,
    output logic       busy,
    output logic [1:0] mode
);

    localparam int unsigned MAXLEN = (SHOW_TICKS > WIN_TICKS) ? SHOW_TICKS : WIN_TICKS;
    localparam int unsigned PW     = $clog2(MAXLEN + 1);

    state_e        state_q, state_d;
    logic [7:0]    led_q, led_d;
    logic [7:0]    saved_q, saved_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] last_idx;
    logic          tick, clr, ready, accept, start;
    logic [1:0]    start_code;
`ifdef EVT_QUEUE_EN
    logic          pend_valid_q, pend_valid_d;
    logic [1:0]    pend_code_q, pend_code_d;
`endif

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    assign last_idx = (state_q == StShowWin) ? PW'(WIN_TICKS - 1) : PW'(SHOW_TICKS - 1);

    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        saved_d    = saved_q;
        phase_d    = phase_q;
        clr        = 1'b0;
        start      = 1'b0;
        start_code = EVT_NONE;
`ifdef EVT_QUEUE_EN
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
`endif

        unique case (state_q)
            StIdle: ready = 1'b1;
`ifdef EVT_QUEUE_EN
            StShowHigh, StShowLow, StShowWin: ready = !pend_valid_q;
`else
            StShowHigh, StShowLow: ready = (evt_code == EVT_WIN);
            StShowWin:             ready = 1'b0;
`endif
            default: ready = 1'b0;
        endcase
        accept = evt_valid && ready;

        if (state_q == StIdle) begin
            if (accept && evt_code != EVT_NONE) begin
                start      = 1'b1;
                start_code = evt_code;
                saved_d    = led_q;
            end else if (tick) begin
                led_d = {led_q[6:0], led_q[7]};
            end
        end else if (accept && evt_code == EVT_WIN && state_q != StShowWin) begin
            // WIN preempts HIGH/LOW, even on their final tick; chase stays saved.
            start      = 1'b1;
            start_code = EVT_WIN;
        end else begin
`ifdef EVT_QUEUE_EN
            if (accept && evt_code != EVT_NONE) begin
                pend_valid_d = 1'b1;
                pend_code_d  = evt_code;
            end
`endif
            if (tick) begin
                if (phase_q == last_idx) begin
                    state_d = StIdle;
                    led_d   = saved_q;
                    phase_d = '0;
`ifdef EVT_QUEUE_EN
                    if (pend_valid_d) begin
                        start        = 1'b1;
                        start_code   = pend_code_d;
                        pend_valid_d = 1'b0;
                    end
`endif
                end else begin
                    led_d   = (led_q == PAT_OFF) ? on_pattern(2'(state_q)) : PAT_OFF;
                    phase_d = phase_q + PW'(1);
                end
            end
        end

        if (start) begin
            state_d = state_e'(start_code);
            led_d   = on_pattern(start_code);
            phase_d = '0;
            clr     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            led_q   <= CHASE_INIT;
            saved_q <= CHASE_INIT;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            saved_q <= saved_d;
            phase_q <= phase_d;
        end
    end

`ifdef EVT_QUEUE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_code_q  <= EVT_NONE;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
        end
    end
`endif

    assign evt_ready = ready;
    assign led       = led_q;
    assign busy      = (state_q != StIdle);
    assign mode      = 2'(state_q);

endmodule
